cube_calc: RTL and testbench

Sequential integer cube unit: computes y = x³ exactly for an unsigned WIDTH-bit operand. It uses a single internal shift-add multiplier run twice, first x·x and then (x·x)·x. It is the forward counterpart of the cube-root unit and shares its start/busy handshake, so the same controller or testbench can drive both. A common use is checking that the floor cube root of y returns x.

---
 rtl/cube_calc_if.sv | 12 +
 rtl/cube_calc.sv | 106 ++++++++++
 tb/tb_cube_calc.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cube_calc_if.sv
// Start/busy handshake bundle for the cube unit. The master side issues start
// and the operand, and the slave side (the cube unit) returns busy, done and the result.
interface cube_calc_if #(parameter int WIDTH = 8);
  logic                 start;
  logic [WIDTH-1:0]     x_bi;
  logic                 busy_o;
  logic                 done_o;
  logic [3*WIDTH-1:0]   y_bo;

  modport master (output start, x_bi, input busy_o, done_o, y_bo);
  modport slave  (input start, x_bi, output busy_o, done_o, y_bo);
endinterface

// File: rtl/cube_calc.sv
// Sequential integer cube unit: y = x^3 using one shift-add multiplier,
// run first as x*x (SQ) and then as (x*x)*x (CUBE). 2*WIDTH+2 cycle latency.
module cube_calc #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  cube_calc_if.slave   bus
);
  localparam int RW = 3 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQ   = 3'd1,
    S_LOAD = 3'd2,
    S_CUBE = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath: one multiplier bit per SQ/CUBE cycle.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d      = bus.x_bi;
          mcand_d  = RW'(bus.x_bi);
          mplier_d = bus.x_bi;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_SQ;
        end
      end
      S_SQ, S_CUBE: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1))
          state_d = (state_q == S_SQ) ? S_LOAD : S_DONE;
      end
      S_LOAD: begin
        // Square becomes the multiplicand; operand is replayed as multiplier.
        mcand_d  = acc_q;
        mplier_d = x_q;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = S_CUBE;
      end
      S_DONE: begin
        y_d     = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers with synchronous reset; rst overrides any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.y_bo   = y_q;
endmodule

// File: tb/tb_cube_calc.sv
// Self-checking bench for cube_calc (WIDTH=8): vector table, random operands
// against an arithmetic model, and hand-written handshake/reset sequences.
module tb_cube_calc;
  localparam int W   = 8;
  localparam int LAT = 2 * W + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cube_calc_if #(.WIDTH(W)) ifc ();
  cube_calc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] x;
    longint       y;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint cube(input longint x);
    return x * x * x;
  endfunction

  function automatic longint icbrt(input longint y);
    longint r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= y) r++;
    return r;
  endfunction

  // Issue one start from idle and check result, latency, busy length and pulse width.
  task automatic run_one(input logic [W-1:0] x, input longint exp, input string tag);
    int lat = 0;
    int busy_cnt = 0;
    bit seen = 0;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.x_bi  = x;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.x_bi  = W'($urandom);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifc.busy_o) busy_cnt++;
      if (ifc.done_o) begin seen = 1; break; end
      @(posedge clk);
      lat++;
    end
    chk({tag, " done seen"}, seen, 1);
    chk({tag, " y"}, ifc.y_bo, exp);
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " busy cycles"}, busy_cnt, LAT);
    chk({tag, " busy low at done"}, ifc.busy_o, 0);
    @(negedge clk);
    chk({tag, " done one cycle"}, ifc.done_o, 0);
    chk({tag, " y holds"}, ifc.y_bo, exp);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{x: 8'd3,   y: 27};
    vecs[1] = '{x: 8'd5,   y: 125};
    vecs[2] = '{x: 8'd10,  y: 1000};
    vecs[3] = '{x: 8'd0,   y: 0};
    vecs[4] = '{x: 8'd1,   y: 1};
    vecs[5] = '{x: 8'd255, y: 64'hFD02FF};

    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.x_bi  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle hold.
    @(negedge clk);
    chk("reset busy", ifc.busy_o, 0);
    chk("reset done", ifc.done_o, 0);
    chk("reset y", ifc.y_bo, 0);
    begin
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
        ifc.x_bi = W'($urandom);
        @(negedge clk);
        if (ifc.busy_o || ifc.done_o || ifc.y_bo != 0) bad++;
      end
      chk("idle no activity", bad, 0);
    end

    // Table vectors.
    for (int i = 0; i < 6; i++)
      run_one(vecs[i].x, vecs[i].y, $sformatf("vec x=%0d", vecs[i].x));

    // Random operands against the model.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] rx;
      rx = W'($urandom);
      run_one(rx, cube(longint'(rx)), $sformatf("rand x=%0d", rx));
    end

    // Start while busy: extra starts and operand churn must be ignored.
    begin
      int dones = 0;
      longint ylast = -1;
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.x_bi  = 8'd4;
      @(posedge clk);
      #1;
      for (int m = 0; m < 30; m++) begin
        @(negedge clk);
        if (ifc.done_o) begin dones++; ylast = longint'(ifc.y_bo); end
        ifc.start = (m == 4 || m == 16) ? 1'b1 : 1'b0;
        ifc.x_bi  = (m == 4 || m == 16) ? 8'd7 : W'($urandom);
      end
      chk("busy-start done count", dones, 1);
      chk("busy-start y", ylast, 64);
    end

    // Reset mid-operation.
    begin
      int dones = 0;
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.x_bi  = 8'd200;
      @(posedge clk);
      #1 ifc.start = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midreset busy", ifc.busy_o, 0);
      chk("midreset y", ifc.y_bo, 0);
      chk("midreset done", ifc.done_o, 0);
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (ifc.done_o) dones++;
      end
      chk("midreset no done", dones, 0);
      run_one(8'd2, 8, "after reset x=2");
    end

    // Back-to-back sweep 0..255 with start held high.
    begin
      int q[$];
      int nxt = 1;
      int gap = 0;
      int first = 1;
      int budget = 0;
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.x_bi  = 8'd0;
      q.push_back(0);
      while (q.size() > 0 && budget < 6000) begin
        @(negedge clk);
        budget++;
        gap++;
        if (ifc.done_o) begin
          int ex;
          ex = q.pop_front();
          chk($sformatf("sweep y x=%0d", ex), ifc.y_bo, cube(longint'(ex)));
          chk($sformatf("sweep cbrt x=%0d", ex), icbrt(longint'(ifc.y_bo)), ex);
          if (!first) chk($sformatf("sweep period x=%0d", ex), gap, LAT + 1);
          first = 0;
          gap = 0;
          if (nxt <= 255) begin
            ifc.x_bi = W'(nxt);
            q.push_back(nxt);
            nxt++;
          end else begin
            ifc.start = 1'b0;
          end
        end else begin
          ifc.x_bi = W'($urandom);
        end
      end
      chk("sweep complete", q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
